// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver:
// active-low segment table, all-off pattern and per-digit record.
package seven_seg_scan_driver_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
        logic       blank;
    } digit_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_seg_hex_decode.sv
// Combinational hex nibble to active-low a..g segment lookup.
module seg_hex_decode
    import seven_seg_scan_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with
// double-buffered digit data committed at the frame boundary.
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   val_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lz_suppress,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [7:0]                led_out,
    output logic                      upd_pending,
    output logic                      frame_tick
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]           div_reg, div_next;
    logic [IDX_W-1:0]           idx_reg, idx_next;
    digit_t [NUM_DIGITS-1:0]    in_digits;
    digit_t [NUM_DIGITS-1:0]    shadow_reg;
    digit_t [NUM_DIGITS-1:0]    active_reg;
    logic                       pending_reg;
    logic                       frame_tick_reg;
    logic [NUM_DIGITS-1:0]      an_reg, an_next;
    logic [7:0]                 led_reg, led_next;
    logic                       div_tc;
    logic                       wrap;
    logic [NUM_DIGITS-1:0]      upper_zero;
    logic [NUM_DIGITS-1:0]      suppress;
    digit_t                     cur_digit;
    logic                       cur_suppress;
    logic [6:0]                 dec_seg;

    // ---------------- divider and digit index ----------------
    assign div_tc = (div_reg == DIV_LAST);
    assign wrap   = div_tc && (idx_reg == IDX_LAST);

    always_comb begin
        div_next = div_reg + 1'b1;
        idx_next = idx_reg;
        if (div_tc) begin
            div_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else begin
            div_reg <= div_next;
            idx_reg <= idx_next;
        end
    end

    // ---------------- input unpacking and suppression ----------------
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign in_digits[gi].hex   = val_in[4*gi +: 4];
        assign in_digits[gi].dp    = dp_in[gi];
        assign in_digits[gi].blank = blank_in[gi];
        if (gi == 0) begin : g_lsd
            assign suppress[gi] = 1'b0;
        end else begin : g_upper
            assign suppress[gi] = lz_suppress && upper_zero[gi];
        end
    end

    // upper_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        logic run;
        upper_zero = '0;
        run        = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run           = run && (active_reg[k].hex == 4'd0);
            upper_zero[k] = run;
        end
    end

    // ---------------- double buffer ----------------
    // A load landing on the wrap cycle bypasses the shadow straight into
    // active so it shows in the frame that starts right now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (load) begin
            shadow_reg <= in_digits;
            if (wrap) begin
                active_reg  <= in_digits;
                pending_reg <= 1'b0;
            end else begin
                pending_reg <= 1'b1;
            end
        end else if (wrap && pending_reg) begin
            active_reg  <= shadow_reg;
            pending_reg <= 1'b0;
        end
    end

    // ---------------- segment pattern ----------------
    assign cur_digit    = active_reg[idx_reg];
    assign cur_suppress = suppress[idx_reg];

    seg_hex_decode u_decode (
        .hex (cur_digit.hex),
        .seg (dec_seg)
    );

    always_comb begin
        led_next = SEG_OFF;
        if (!cur_digit.blank) begin
            led_next[7]   = ~cur_digit.dp;
            led_next[6:0] = cur_suppress ? 7'h7F : dec_seg;
        end
    end

    assign an_next = ~(NUM_DIGITS'(1) << idx_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg         <= '1;
            led_reg        <= SEG_OFF;
            frame_tick_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            led_reg        <= led_next;
            frame_tick_reg <= wrap;
        end
    end

    assign an_out      = an_reg;
    assign led_out     = led_reg;
    assign upd_pending = pending_reg;
    assign frame_tick  = frame_tick_reg;

endmodule
